// File: rtl/rip_branch_resolver_pkg.sv
// Shared branch-predictor encodings used by the PHT predictor and its resolver.
`default_nettype none

package rip_branch_predictor_const;

  // 2-bit saturating-counter states; NONE marks "no counter read".
  typedef enum logic [2:0] {
    STRONGLY_UNTAKEN = 3'd0,
    WEAKLY_UNTAKEN   = 3'd1,
    WEAKLY_TAKEN     = 3'd2,
    STRONGLY_TAKEN   = 3'd3,
    NONE             = 3'd4
  } rip_bpw_t;

endpackage

`default_nettype wire

// File: rtl/rip_bp_inflight_fifo.sv
// Synchronous FIFO of in-flight branch predictions with clear; push+pop same cycle is legal.
`default_nettype none

module rip_bp_inflight_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic                  do_push;
  logic                  do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (rstn && !clear && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/rip_branch_resolver.sv
// Matches in-flight predictions against execute outcomes, drives the predictor
// update port, raises mispredict redirects and keeps saturating branch counters.
`default_nettype none

module rip_branch_resolver
  import rip_branch_predictor_const::*;
#(
  parameter int PHT_LSB   = 0,
  parameter int PHT_MSB   = 31,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   enq_valid,
  output logic                   enq_ready,
  input  logic [PHT_MSB-PHT_LSB:0] enq_index,
  input  rip_bpw_t               enq_weight,
  input  logic                   enq_pred,
  input  logic                   res_valid,
  input  logic                   res_taken,
  input  logic [31:0]            res_next_pc,
  output logic                   update,
  output logic [PHT_MSB-PHT_LSB:0] update_index,
  output rip_bpw_t               update_weight,
  output logic                   actual,
  output logic                   mispredict,
  output logic [31:0]            redirect_pc,
  output logic                   res_error,
  output logic [CNT_WIDTH-1:0]   branch_count,
  output logic [CNT_WIDTH-1:0]   mispredict_count
);

  localparam int IW = PHT_MSB - PHT_LSB + 1;

  typedef struct packed {
    logic [IW-1:0] index;
    rip_bpw_t      weight;
    logic          pred;
  } entry_t;

  entry_t head;
  entry_t tail;
  logic   full;
  logic   empty;
  logic   ready_en;
  logic   enq_fire;
  logic   res_fire;
  logic   res_hit;
  logic   res_miss;
  logic   mis;

  assign tail     = '{index: enq_index, weight: enq_weight, pred: enq_pred};
  // ready_en keeps enq_ready low while reset is held.
  assign enq_ready = ~full & ready_en;
  assign enq_fire  = enq_valid & enq_ready & ~stall & ~flush;
  assign res_fire  = res_valid & ~stall & ~flush;
  assign res_hit   = res_fire & ~empty;
  assign res_miss  = res_fire & empty;
  assign mis       = res_hit & (head.pred != res_taken);

  rip_bp_inflight_fifo #(
    .DATA_WIDTH ($bits(entry_t)),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (flush | mis),
    .push      (enq_fire & ~mis),
    .push_data (tail),
    .pop       (res_hit),
    .pop_data  (head),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ready_en         <= 1'b0;
      update           <= 1'b0;
      update_index     <= '0;
      update_weight    <= STRONGLY_UNTAKEN;
      actual           <= 1'b0;
      mispredict       <= 1'b0;
      redirect_pc      <= '0;
      res_error        <= 1'b0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      ready_en   <= 1'b1;
      update     <= res_hit;
      mispredict <= mis;
      if (res_hit) begin
        update_index  <= head.index;
        update_weight <= head.weight;
        actual        <= res_taken;
        redirect_pc   <= res_next_pc;
        if (branch_count != '1) branch_count <= branch_count + CNT_WIDTH'(1);
      end
      if (mis && mispredict_count != '1)
        mispredict_count <= mispredict_count + CNT_WIDTH'(1);
      if (res_miss) res_error <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rip_branch_resolver.sv
// Scoreboard bench: directed stimulus pushes expected updates; a negedge monitor checks them.
`default_nettype none

module tb_rip_branch_resolver;
  import rip_branch_predictor_const::*;

  logic        clk = 1'b0;
  logic        rstn, stall, flush, enq_valid, enq_ready, enq_pred;
  logic        res_valid, res_taken, update, actual, mispredict, res_error;
  logic [31:0] enq_index, res_next_pc, update_index, redirect_pc;
  logic [31:0] branch_count, mispredict_count;
  rip_bpw_t    enq_weight, update_weight;

  always #5 clk = ~clk;

  rip_branch_resolver dut (
    .clk(clk), .rstn(rstn), .stall(stall), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_index(enq_index),
    .enq_weight(enq_weight), .enq_pred(enq_pred),
    .res_valid(res_valid), .res_taken(res_taken), .res_next_pc(res_next_pc),
    .update(update), .update_index(update_index), .update_weight(update_weight),
    .actual(actual), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .res_error(res_error), .branch_count(branch_count),
    .mispredict_count(mispredict_count)
  );

  typedef struct {
    logic [31:0] idx;
    logic [2:0]  w;
    logic        act;
    logic        mis;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every update pulse must match the oldest expected record.
  always @(negedge clk) begin
    if (rstn === 1'b1 && update === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_update: got update idx=0x%0h expected no update", update_index);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("upd_index", update_index, e.idx);
        chk("upd_weight", 32'(update_weight), 32'(e.w));
        chk("upd_actual", 32'(actual), 32'(e.act));
        chk("upd_mispredict", 32'(mispredict), 32'(e.mis));
        if (e.mis) chk("upd_redirect_pc", redirect_pc, e.pc);
      end
    end else if (rstn === 1'b1 && mispredict === 1'b1) begin
      chk("mispredict_without_update", 32'(mispredict), 32'd0);
    end
  end

  task automatic drive(input logic ev, input logic [31:0] idx, input logic [2:0] w,
                       input logic p, input logic rv, input logic rt,
                       input logic [31:0] npc, input logic st, input logic fl);
    enq_valid = ev; enq_index = idx; enq_weight = rip_bpw_t'(w); enq_pred = p;
    res_valid = rv; res_taken = rt; res_next_pc = npc; stall = st; flush = fl;
    @(posedge clk);
    #1;
    enq_valid = 0; enq_index = 0; enq_weight = STRONGLY_UNTAKEN; enq_pred = 0;
    res_valid = 0; res_taken = 0; res_next_pc = 0; stall = 0; flush = 0;
  endtask

  task automatic enq(input logic [31:0] idx, input logic [2:0] w, input logic p);
    drive(1, idx, w, p, 0, 0, 0, 0, 0);
  endtask

  task automatic expect_upd(input logic [31:0] idx, input logic [2:0] w,
                            input logic a, input logic m, input logic [31:0] pc);
    exp_t e;
    e.idx = idx; e.w = w; e.act = a; e.mis = m; e.pc = pc;
    exp_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 0;
    enq_valid = 0; enq_index = 0; enq_weight = STRONGLY_UNTAKEN; enq_pred = 0;
    res_valid = 0; res_taken = 0; res_next_pc = 0; stall = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_update", 32'(update), 0);
    chk("rst_branch_count", branch_count, 0);
    chk("rst_res_error", 32'(res_error), 0);
    rstn = 1;
    @(posedge clk); #1;
    chk("rst_enq_ready", 32'(enq_ready), 1);

    // Correct prediction.
    enq(5, 3'd2, 1);
    expect_upd(5, 3'd2, 1, 0, 32'h100);
    drive(0, 0, 0, 0, 1, 1, 32'h100, 0, 0);
    chk("t1_branch_count", branch_count, 1);
    chk("t1_mispredict_count", mispredict_count, 0);

    // Mispredict drops the younger entry.
    enq(3, 3'd3, 1);
    enq(4, 3'd1, 1);
    expect_upd(3, 3'd3, 0, 1, 32'h200);
    drive(0, 0, 0, 0, 1, 0, 32'h200, 0, 0);
    chk("t2_branch_count", branch_count, 2);
    chk("t2_mispredict_count", mispredict_count, 1);

    // Fill to full; idx=4 must be gone so four slots are free.
    for (int i = 10; i < 14; i++) begin
      chk("t3_ready_before_fill", 32'(enq_ready), 1);
      enq(i, 3'(i % 4), 1);
    end
    chk("t3_full_ready", 32'(enq_ready), 0);
    expect_upd(10, 3'd2, 1, 0, 0);
    drive(1, 14, 3'd0, 1, 1, 1, 32'h300, 0, 0);
    chk("t3_ready_after_pop", 32'(enq_ready), 1);
    for (int k = 0; k < 6; k++) begin
      int ri;
      ri = (k < 3) ? 11 + k : 20 + (k - 3);
      expect_upd(ri, 3'(ri % 4), 1, 0, 0);
      drive(1, 20 + k, 3'((20 + k) % 4), 1, 1, 1, 32'h400, 0, 0);
    end
    expect_upd(23, 3'd3, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 32'h500, 0, 0);
    expect_upd(24, 3'd0, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 32'h500, 0, 0);
    expect_upd(25, 3'd1, 0, 1, 32'h600);
    drive(0, 0, 0, 0, 1, 0, 32'h600, 0, 0);
    chk("t3_branch_count", branch_count, 12);
    chk("t3_mispredict_count", mispredict_count, 2);

    // Resolve on empty FIFO.
    drive(0, 0, 0, 0, 1, 1, 32'h700, 0, 0);
    chk("t4_res_error", 32'(res_error), 1);
    chk("t4_branch_count", branch_count, 12);
    @(posedge clk); #1;
    chk("t4_res_error_sticky", 32'(res_error), 1);

    // Stall blocks both enq and resolve.
    enq(30, 3'd2, 1);
    drive(1, 31, 3'd2, 1, 1, 1, 32'h800, 1, 0);
    chk("t5_stall_branch_count", branch_count, 12);
    expect_upd(30, 3'd2, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 32'h800, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 32'h800, 0, 0);
    chk("t5_after_stall_branch_count", branch_count, 13);

    // Flush with three entries and a resolve.
    enq(40, 3'd0, 1);
    enq(41, 3'd1, 1);
    enq(42, 3'd2, 1);
    drive(0, 0, 0, 0, 1, 1, 32'h900, 0, 1);
    drive(0, 0, 0, 0, 1, 1, 32'h900, 0, 0);
    chk("t5_flush_branch_count", branch_count, 13);
    enq(43, 3'd3, 0);
    expect_upd(43, 3'd3, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 32'hA00, 0, 0);
    chk("t5_post_flush_branch_count", branch_count, 14);

    // Reset with entries in flight.
    enq(50, 3'd2, 1);
    enq(51, 3'd2, 1);
    rstn = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("t6_update", 32'(update), 0);
    chk("t6_mispredict", 32'(mispredict), 0);
    chk("t6_update_index", update_index, 0);
    chk("t6_redirect_pc", redirect_pc, 0);
    chk("t6_branch_count", branch_count, 0);
    chk("t6_mispredict_count", mispredict_count, 0);
    chk("t6_res_error", 32'(res_error), 0);
    rstn = 1;
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 1, 1, 32'hB00, 0, 0);
    chk("t6_res_error_after", 32'(res_error), 1);
    chk("t6_branch_count_after", branch_count, 0);

    repeat (3) @(posedge clk);
    chk("pending_expected_updates", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
